lsm_reservoir_param: RTL and testbench

- Parametrised liquid-state-machine reservoir of N leaky integrate-and-fire (LIF) neurons on a ring topology.
- Inputs per step: external excitation, direct spike injection, nearest-neighbour recurrent excitation and opposite-neuron inhibition.
- Per-neuron spike counts accumulate over a fixed step window, then latch into a readout bank for the downstream classifier.
- Generalises the fixed 16-neuron reservoir: neuron count, widths, weights, leak, refractory period and window length are all parameters.

---
 rtl/lsm_reservoir_param.sv | 168 ++++++++++++++++
 tb/tb_lsm_reservoir_param.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/lsm_reservoir_param.sv
// Ring-topology LIF reservoir: N neurons step in parallel, spike counts are
// gathered per window and latched into a readout bank for a classifier.

module lsm_lif_neuron #(
   parameter int VW         = 8,
   parameter int THRESH     = 64,
   parameter int W_EXT      = 20,
   parameter int W_REC      = 8,
   parameter int W_INH      = 16,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRAC     = 2,
   parameter int CW         = 8
) (
   input  logic          clock,
   input  logic          flush,
   input  logic          step,
   input  logic          win_end,
   input  logic          ext_in,
   input  logic          inj_in,
   input  logic          nb_l,
   input  logic          nb_r,
   input  logic          opp,
   output logic          spike_q,
   output logic [CW-1:0] cnt_live
);
   localparam int SW   = VW + 4;
   localparam int RW   = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
   localparam int VMAX = (1 << VW) - 1;

   logic [VW-1:0]        v_q, v_d, tc;
   logic [RW-1:0]        refr_q, refr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 spike_d, fire;
   logic signed [SW-1:0] t;

   always_comb begin
      t = SW'(int'(v_q) - int'(v_q >> LEAK_SHIFT)
            + W_EXT * int'(ext_in) + W_EXT * int'(inj_in)
            + W_REC * (int'(nb_l) + int'(nb_r)) - W_INH * int'(opp));
      if (t < 0)                tc = '0;
      else if (t > SW'(VMAX))   tc = '1;
      else                      tc = t[VW-1:0];
      fire = int'(tc) >= THRESH;
   end

   always_comb begin
      v_d      = v_q;
      refr_d   = refr_q;
      spike_d  = spike_q;
      cnt_live = cnt_q;
      cnt_d    = cnt_q;
      if (step) begin
         if (refr_q != '0) begin
            v_d     = '0;
            refr_d  = refr_q - RW'(1);
            spike_d = 1'b0;
         end else if (fire) begin
            v_d     = '0;
            refr_d  = RW'(REFRAC);
            spike_d = 1'b1;
         end else begin
            v_d     = tc;
            spike_d = 1'b0;
         end
         // saturate rather than wrap so a busy neuron reads as "max" downstream
         if (spike_d && cnt_q != '1) cnt_live = cnt_q + CW'(1);
         cnt_d = win_end ? '0 : cnt_live;
      end
   end

   always_ff @(posedge clock) begin
      if (flush) begin
         v_q     <= '0;
         refr_q  <= '0;
         spike_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         v_q     <= v_d;
         refr_q  <= refr_d;
         spike_q <= spike_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

module lsm_reservoir_param #(
   parameter int N          = 16,
   parameter int EXT_IN     = 8,
   parameter int VW         = 8,
   parameter int THRESH     = 64,
   parameter int W_EXT      = 20,
   parameter int W_REC      = 8,
   parameter int W_INH      = 16,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRAC     = 2,
   parameter int WINDOW     = 100,
   parameter int CW         = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              step_en,
   input  logic              write,
   input  logic [EXT_IN-1:0] ein_ext,
   input  logic [N-1:0]      spikes_in,
   output logic [N-1:0]      spike_out,
   output logic [N*CW-1:0]   count_bus,
   output logic              window_done,
   output logic              readout_valid
);
   localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

   logic [WW-1:0]   win_q, win_d;
   logic [N*CW-1:0] bus_q, bus_d, live;
   logic            rv_q, rv_d, done_q, done_d, win_end;
   logic [N-1:0]    s;

   for (genvar i = 0; i < N; i++) begin : g_n
      lsm_lif_neuron #(
         .VW(VW), .THRESH(THRESH), .W_EXT(W_EXT), .W_REC(W_REC), .W_INH(W_INH),
         .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC), .CW(CW)
      ) u_n (
         .clock    (clock),
         .flush    (reset | clear),
         .step     (step_en),
         .win_end  (win_end),
         .ext_in   (ein_ext[i % EXT_IN]),
         .inj_in   (spikes_in[i]),
         .nb_l     (s[(i + N - 1) % N]),
         .nb_r     (s[(i + 1) % N]),
         .opp      (s[(i + N / 2) % N]),
         .spike_q  (s[i]),
         .cnt_live (live[i*CW +: CW])
      );
   end

   always_comb begin
      win_end = step_en && (win_q == WW'(WINDOW - 1));
      win_d   = win_q;
      if (step_en) win_d = win_end ? '0 : win_q + WW'(1);
      bus_d  = (win_end && write) ? live : bus_q;
      rv_d   = rv_q || (win_end && write);
      done_d = win_end;
   end

   // clear aborts the window but leaves the last latched readout visible
   always_ff @(posedge clock) begin
      if (reset) begin
         win_q  <= '0;
         bus_q  <= '0;
         rv_q   <= 1'b0;
         done_q <= 1'b0;
      end else if (clear) begin
         win_q  <= '0;
         done_q <= 1'b0;
      end else begin
         win_q  <= win_d;
         bus_q  <= bus_d;
         rv_q   <= rv_d;
         done_q <= done_d;
      end
   end

   assign spike_out     = s;
   assign count_bus     = bus_q;
   assign window_done   = done_q;
   assign readout_valid = rv_q;
endmodule

// File: tb/tb_lsm_reservoir_param.sv
// Directed bench for lsm_reservoir_param: neuron-0 drive with a scoreboard of
// per-step expectations, plus a CW=4 instance saturated by full input drive.

module tb_lsm_reservoir_param;
   logic          clock = 1'b0;
   logic          reset, clear, step_en, write;
   logic [7:0]    ein_ext;
   logic [15:0]   spikes_in;
   logic [15:0]   spike_out, spike_out_s;
   logic [127:0]  count_bus;
   logic [63:0]   count_bus_s;
   logic          window_done, readout_valid, window_done_s, readout_valid_s;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       spk;
      logic       wd;
      logic [7:0] bus;
      logic       rv;
      int         ph;
   } exp_t;
   exp_t sb[$];

   // behavioural state of neuron 0 under the single-injection stimulus
   int         ph, win;
   logic       m_spk, m_rv;
   logic [7:0] m_cnt, m_bus;
   int         vexp[7] = '{20, 20, 38, 38, 54, 54, 0};

   always #5 clock = ~clock;

   lsm_reservoir_param dut (
      .clock(clock), .reset(reset), .clear(clear), .step_en(step_en), .write(write),
      .ein_ext(ein_ext), .spikes_in(spikes_in), .spike_out(spike_out),
      .count_bus(count_bus), .window_done(window_done), .readout_valid(readout_valid)
   );

   lsm_reservoir_param #(.CW(4)) dut_s (
      .clock(clock), .reset(reset), .clear(clear), .step_en(step_en), .write(write),
      .ein_ext(8'hFF), .spikes_in(16'hFFFF), .spike_out(spike_out_s),
      .count_bus(count_bus_s), .window_done(window_done_s), .readout_valid(readout_valid_s)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_flush(input bit hard);
      ph = 0; win = 0; m_spk = 1'b0; m_cnt = '0;
      if (hard) begin m_bus = '0; m_rv = 1'b0; end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      model_flush(1'b1);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clock); #1;
      clear = 1'b0;
      model_flush(1'b0);
   endtask

   task automatic do_step(input bit en);
      exp_t e;
      step_en = en;
      e.wd = 1'b0;
      e.ph = -1;
      if (en) begin
         ph++; win++;
         m_spk = (ph % 6 == 4);
         if (m_spk && m_cnt != 8'hFF) m_cnt++;
         if (win == 100) begin
            e.wd = 1'b1;
            if (write) begin m_bus = m_cnt; m_rv = 1'b1; end
            m_cnt = '0; win = 0;
         end
         e.ph = ph;
      end
      e.spk = m_spk; e.bus = m_bus; e.rv = m_rv;
      sb.push_back(e);
      @(posedge clock); #1;
      e = sb.pop_front();
      chk("spike0", spike_out[0], e.spk);
      chk("nbr_opp_quiet", {spike_out[15], spike_out[8], spike_out[1]}, 0);
      chk("window_done", window_done, e.wd);
      chk("count0", count_bus[7:0], e.bus);
      chk("readout_valid", readout_valid, e.rv);
      if (e.ph == 5) begin
         chk("v1_after_spike", dut.g_n[1].u_n.v_q, 8);
         chk("v15_after_spike", dut.g_n[15].u_n.v_q, 8);
      end
      if (e.ph > 0) chk("v8_inhibited", dut.g_n[8].u_n.v_q, 0);
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; step_en = 1'b0; write = 1'b1;
      ein_ext = '0; spikes_in = 16'h0001;
      model_flush(1'b1);
      @(posedge clock); #1;
      do_reset();
      chk("rst_spike_out", spike_out, 0);
      chk("rst_count_bus", count_bus, 0);
      chk("rst_window_done", window_done, 0);
      chk("rst_readout_valid", readout_valid, 0);

      // alternating step_en: state holds on idle edges, spike on 7th edge
      for (int k = 0; k < 7; k++) begin
         do_step(k % 2 == 0);
         chk("v0_toggle", dut.g_n[0].u_n.v_q, vexp[k]);
      end
      chk("toggle_spike_edge7", spike_out[0], 1);

      // full window from reset
      do_reset();
      repeat (100) do_step(1'b1);
      chk("win1_count0", count_bus[7:0], 17);
      chk("win1_others_zero", count_bus[127:8], 0);
      chk("sat_count_bus", count_bus_s, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("sat_window_done", window_done_s, 1);

      // soft clear keeps readout bank
      repeat (10) do_step(1'b1);
      do_clear();
      chk("clr_count0", count_bus[7:0], 17);
      chk("clr_readout_valid", readout_valid, 1);
      chk("clr_spike_out", spike_out, 0);
      chk("clr_v0", dut.g_n[0].u_n.v_q, 0);

      // write=0 window, then write=1 window
      do_reset();
      write = 1'b0;
      repeat (100) do_step(1'b1);
      chk("nowrite_count_bus", count_bus, 0);
      chk("nowrite_readout_valid", readout_valid, 0);
      write = 1'b1;
      repeat (100) do_step(1'b1);
      chk("win2_count0", count_bus[7:0], m_bus);
      chk("win2_readout_valid", readout_valid, 1);

      // reset mid-window aborts partial counts
      do_reset();
      repeat (50) do_step(1'b1);
      step_en = 1'b1;
      do_reset();
      chk("midrst_spike_out", spike_out, 0);
      chk("midrst_count_bus", count_bus, 0);
      chk("midrst_v0", dut.g_n[0].u_n.v_q, 0);
      chk("midrst_readout_valid", readout_valid, 0);
      repeat (100) do_step(1'b1);
      chk("resume_count0", count_bus[7:0], 17);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
